// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared CPU constants and fetch queue entry layout
package fetch_queue_pkg;

    localparam logic [31:0] FQ_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0000;
    localparam int          FQ_ENTRY_W   = 65;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH x 65 entry array, one write port, combinational read
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [FQ_ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [FQ_ENTRY_W-1:0] o_rdata
);

    // No reset: validity is tracked by the controller's count.
    logic [FQ_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between IFU and decode
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     out_adel,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    fq_entry_t             w_wentry;
    fq_entry_t             w_head;
    logic [FQ_ENTRY_W-1:0] w_rdata;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready depends only on registered count, never on out_ready.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    assign w_push = in_valid && !w_full && !flush;
    assign w_pop  = out_ready && !w_empty && !flush;

    always_comb begin
        w_wentry       = '0;
        w_wentry.adel  = (in_pc[1:0] != 2'b00);
        w_wentry.pc    = in_pc;
        w_wentry.instr = in_instr;
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wentry),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign w_head = fq_entry_t'(w_rdata);

    always_comb begin
        out_instr = FQ_NOP_INSTR;
        out_pc    = RESET_PC;
        out_adel  = 1'b0;
        if (!w_empty) begin
            out_instr = w_head.instr;
            out_pc    = w_head.pc;
            out_adel  = w_head.adel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the out_pc value while empty.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the IFU presents a fetched word.
REQ-006 SHALL have port in_instr, input, 32, meaning the fetched instruction.
REQ-007 SHALL have port in_pc, input, 32, meaning the PC of in_instr.
REQ-008 SHALL have port in_ready, output, 1, meaning the queue accepts this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning the head entry is valid for decode.
REQ-010 SHALL have port out_ready, input, 1, meaning decode consumes the head this cycle.
REQ-011 SHALL have port out_instr, output, 32, meaning the head instruction.
REQ-012 SHALL have port out_pc, output, 32, meaning the head PC.
REQ-013 SHALL have port out_adel, output, 1, meaning the head PC was misaligned (in_pc[1:0]!=0).
REQ-014 SHALL have port flush, input, 1, meaning a branch/jump redirect; discard all entries.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, meaning the number of occupied entries.

Function
REQ-016 SHALL perform a push when in_valid && in_ready && !flush, and a pop when out_valid && out_ready && !flush.
REQ-017 SHALL drive in_ready = (count != DEPTH), with no combinational path from out_ready.
REQ-018 SHALL have latency 1 (no bypass): a word pushed into an empty queue appears on out_* in the next cycle.
REQ-019 SHALL, on simultaneous push and pop, leave count unchanged and keep both pointers advancing.
REQ-020 SHALL, when full, refuse a push (in_ready=0) even if a pop occurs the same cycle.
REQ-021 SHALL give flush priority over push and pop: on the next edge count=0, the pointers are equal, and the same-cycle input is dropped.
REQ-022 SHALL wrap the read/write pointers modulo DEPTH and derive full/empty from count.
REQ-023 SHALL capture adel = (in_pc[1:0] != 2'b00) per entry at push time; the word is still queued.
REQ-024 SHALL, when out_valid=0, drive out_instr=32'h0 (nop), out_pc=RESET_PC, out_adel=0.
REQ-025 SHALL keep out_* stable while out_valid=1 && out_ready=0.
REQ-026 SHALL ignore out_ready when empty and in_valid when full (no state change, no error).

Reset
REQ-027 SHALL, while reset=0, asynchronously force count=0, both pointers to 0, out_valid=0, out_instr=0, out_pc=RESET_PC, out_adel=0, in_ready=1.
REQ-028 SHALL, if reset is asserted mid-operation, lose all entries; the storage array needs no clearing.
REQ-029 SHALL allow the first push on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place RESET_PC, the nop encoding 32'h0 and the entry layout {adel, pc, instr} (65 bits) in the shared CPU constants package.
REQ-031 SHALL contain one natural sub-module, fq_storage: a DEPTH x 65 register array with write port and combinational read port.
REQ-032 SHALL keep the control logic (pointers, count, handshake) in fetch_queue.

Verification
REQ-033 SHALL verify push 0x3000/0x24010001 into empty -> out_valid=1, out_pc=0x3000 one cycle later, count=1.
REQ-034 SHALL verify 4 pushes with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is dropped; then pops return 0x3000, 0x3004, 0x3008, 0x300C in order.
REQ-035 SHALL verify continuous in_valid/out_ready with an incrementing PC for 20 cycles -> count steady at 1, PCs in order across wrap.
REQ-036 SHALL verify flush with count=3 and in_valid=1 -> count=0, out_valid=0, out_pc=0x3000 next cycle; the flushed-cycle input is absent.
REQ-037 SHALL verify push with in_pc=0x3002 -> out_adel=1 for that entry only.
REQ-038 SHALL verify reset=0 asserted between edges with count=2 -> out_valid=0 and count=0 immediately, before any clock edge.
